// File: rtl/mindy_md_fanout.sv
// mindy_md_fanout
//   Broadcasts every meta-data beat to MD_CHANNELS independent first-word-fall-through
//   FIFOs, each with its own depth, back-pressure and enable bit. Frame data either
//   passes straight through or, with MINDY_FD_FIFO_EN defined, is buffered in an
//   FD_DEPTH-entry FIFO.
//
// Build option
//   MINDY_FD_FIFO_EN : defined -> frame data buffered; undefined -> combinational bypass.
//
// Ports
//   clk, resetn                        : single clock, asynchronous active-low reset
//   AXIS_FD_IN_*  / AXIS_FD_OUT_*      : frame-data input / output streams
//   AXIS_MD_IN_*                       : meta-data input stream
//   AXIS_MD_OUT_TDATA/TVALID/TREADY    : per-channel meta-data outputs, channel n at
//                                        TDATA[n*DATA_WBITS +: DATA_WBITS]
//   md_chan_en                         : 1 = channel receives new meta-data
//   md_stall_count                     : saturating count of stalled input cycles

// Generic FWFT FIFO with extra-MSB pointers (full = low bits equal, MSBs differ).
module mindy_md_fanout_fifo #(
    parameter int WBITS = 512,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_wr_en,
    input  logic [WBITS-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WBITS-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WBITS-1:0] r_mem [DEPTH];
    logic             w_wr;
    logic             w_rd;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_wr      = i_wr_en & ~o_full;
    assign w_rd      = i_rd_en & ~o_empty;
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Storage is not reset: contents are meaningless once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
endmodule

module mindy_md_fanout #(
    parameter int DATA_WBITS  = 512,
    parameter int MD_CHANNELS = 2,
    parameter int MD_DEPTH    = 16,
    parameter int FD_DEPTH    = 16
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [DATA_WBITS-1:0]             AXIS_FD_IN_TDATA,
    input  logic                              AXIS_FD_IN_TVALID,
    output logic                              AXIS_FD_IN_TREADY,
    output logic [DATA_WBITS-1:0]             AXIS_FD_OUT_TDATA,
    output logic                              AXIS_FD_OUT_TVALID,
    input  logic                              AXIS_FD_OUT_TREADY,
    input  logic [DATA_WBITS-1:0]             AXIS_MD_IN_TDATA,
    input  logic                              AXIS_MD_IN_TVALID,
    output logic                              AXIS_MD_IN_TREADY,
    output logic [MD_CHANNELS*DATA_WBITS-1:0] AXIS_MD_OUT_TDATA,
    output logic [MD_CHANNELS-1:0]            AXIS_MD_OUT_TVALID,
    input  logic [MD_CHANNELS-1:0]            AXIS_MD_OUT_TREADY,
    input  logic [MD_CHANNELS-1:0]            md_chan_en,
    output logic [31:0]                       md_stall_count
);
    logic [MD_CHANNELS-1:0] w_md_full;
    logic [MD_CHANNELS-1:0] w_md_empty;
    logic                   w_md_wr;
    logic [31:0]            r_md_stall_count;

    // Ready depends only on registered pointer state and the enable mask, never on
    // any output TREADY: a full FIFO being read this cycle still blocks the input.
    assign AXIS_MD_IN_TREADY  = resetn & (&(~md_chan_en | ~w_md_full));
    assign w_md_wr            = AXIS_MD_IN_TVALID & AXIS_MD_IN_TREADY;
    assign AXIS_MD_OUT_TVALID = ~w_md_empty;
    assign md_stall_count     = r_md_stall_count;

    for (genvar n = 0; n < MD_CHANNELS; n++) begin : g_md_chan
        mindy_md_fanout_fifo #(
            .WBITS (DATA_WBITS),
            .DEPTH (MD_DEPTH)
        ) u_md_fifo (
            .clk       (clk),
            .resetn    (resetn),
            .i_wr_en   (w_md_wr & md_chan_en[n]),
            .i_wr_data (AXIS_MD_IN_TDATA),
            .i_rd_en   (AXIS_MD_OUT_TVALID[n] & AXIS_MD_OUT_TREADY[n]),
            .o_rd_data (AXIS_MD_OUT_TDATA[n*DATA_WBITS +: DATA_WBITS]),
            .o_full    (w_md_full[n]),
            .o_empty   (w_md_empty[n])
        );
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_md_stall_count <= '0;
        end else if (AXIS_MD_IN_TVALID && !AXIS_MD_IN_TREADY && (r_md_stall_count != '1)) begin
            r_md_stall_count <= r_md_stall_count + 32'd1;
        end
    end

`ifdef MINDY_FD_FIFO_EN
    logic w_fd_full;
    logic w_fd_empty;

    assign AXIS_FD_IN_TREADY  = resetn & ~w_fd_full;
    assign AXIS_FD_OUT_TVALID = ~w_fd_empty;

    mindy_md_fanout_fifo #(
        .WBITS (DATA_WBITS),
        .DEPTH (FD_DEPTH)
    ) u_fd_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .i_wr_en   (AXIS_FD_IN_TVALID & AXIS_FD_IN_TREADY),
        .i_wr_data (AXIS_FD_IN_TDATA),
        .i_rd_en   (AXIS_FD_OUT_TVALID & AXIS_FD_OUT_TREADY),
        .o_rd_data (AXIS_FD_OUT_TDATA),
        .o_full    (w_fd_full),
        .o_empty   (w_fd_empty)
    );
`else
    // FD_DEPTH has no role in the bypass build.
    logic w_unused_fd_depth;
    assign w_unused_fd_depth  = ^FD_DEPTH;

    assign AXIS_FD_OUT_TDATA  = AXIS_FD_IN_TDATA;
    assign AXIS_FD_OUT_TVALID = AXIS_FD_IN_TVALID & resetn;
    assign AXIS_FD_IN_TREADY  = AXIS_FD_OUT_TREADY & resetn;
`endif
endmodule

// File: tb/tb_mindy_md_fanout.sv
// Self-checking bench for mindy_md_fanout: randomized and directed meta-data traffic
// compared cycle by cycle against per-channel reference queues; frame-data path checked
// in whichever mode the build selects.
module tb_mindy_md_fanout;
    localparam int W     = 32;
    localparam int CH    = 4;
    localparam int DEPTH = 4;
    localparam int FDD   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn;
    logic [W-1:0]  fd_in_data, fd_out_data;
    logic          fd_in_valid, fd_in_ready, fd_out_valid, fd_out_ready;
    logic [W-1:0]  md_in_data;
    logic          md_in_valid, md_in_ready;
    logic [CH*W-1:0] md_out_data;
    logic [CH-1:0] md_out_valid, md_out_ready, md_en;
    logic [31:0]   stall_cnt;

    mindy_md_fanout #(
        .DATA_WBITS  (W),
        .MD_CHANNELS (CH),
        .MD_DEPTH    (DEPTH),
        .FD_DEPTH    (FDD)
    ) dut (
        .clk                (clk),
        .resetn             (resetn),
        .AXIS_FD_IN_TDATA   (fd_in_data),
        .AXIS_FD_IN_TVALID  (fd_in_valid),
        .AXIS_FD_IN_TREADY  (fd_in_ready),
        .AXIS_FD_OUT_TDATA  (fd_out_data),
        .AXIS_FD_OUT_TVALID (fd_out_valid),
        .AXIS_FD_OUT_TREADY (fd_out_ready),
        .AXIS_MD_IN_TDATA   (md_in_data),
        .AXIS_MD_IN_TVALID  (md_in_valid),
        .AXIS_MD_IN_TREADY  (md_in_ready),
        .AXIS_MD_OUT_TDATA  (md_out_data),
        .AXIS_MD_OUT_TVALID (md_out_valid),
        .AXIS_MD_OUT_TREADY (md_out_ready),
        .md_chan_en         (md_en),
        .md_stall_count     (stall_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one queue of expected beats per channel plus a stall counter.
    logic [W-1:0]  mq [CH][$];
    logic [31:0]   m_stall;

    logic          exp_rdy, obs_rdy, accepted;
    logic [CH-1:0] exp_vld, obs_vld;
    logic [W-1:0]  exp_data [CH];
    logic [W-1:0]  obs_data [CH];
    logic [31:0]   exp_stall, obs_stall;

    function automatic bit model_busy();
        for (int n = 0; n < CH; n++) if (mq[n].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Sample DUT and model at the falling edge, then advance the model by the
    // handshakes that the next rising edge performs.
    task automatic tick();
        @(negedge clk);
        if (!resetn) begin
            for (int n = 0; n < CH; n++) mq[n].delete();
            m_stall = '0;
        end
        exp_rdy = resetn;
        for (int n = 0; n < CH; n++) if (md_en[n] && mq[n].size() >= DEPTH) exp_rdy = 1'b0;
        for (int n = 0; n < CH; n++) begin
            exp_vld[n]  = (mq[n].size() != 0);
            exp_data[n] = exp_vld[n] ? mq[n][0] : '0;
            obs_data[n] = md_out_data[n*W +: W];
        end
        exp_stall = m_stall;
        obs_rdy   = md_in_ready;
        obs_vld   = md_out_valid;
        obs_stall = stall_cnt;
        accepted  = resetn && md_in_valid && exp_rdy;
        if (resetn) begin
            for (int n = 0; n < CH; n++) if (exp_vld[n] && md_out_ready[n]) void'(mq[n].pop_front());
            if (accepted) for (int n = 0; n < CH; n++) if (md_en[n]) mq[n].push_back(md_in_data);
            if (md_in_valid && !exp_rdy && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; md_in_valid = 1'b1; md_in_data = 32'h55; md_en = '1; md_out_ready = '1;
        fd_in_valid = 1'b1; fd_in_data = 32'h77; fd_out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin resetn = 1'b1; md_in_valid = 1'b0; fd_in_valid = 1'b0; end
            tick();
            checks++; if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL reset_md_in_tready c=%0d got %b exp %b", c, obs_rdy, exp_rdy); end
            checks++; if (obs_vld !== exp_vld) begin errors++; $display("FAIL reset_md_out_tvalid c=%0d got %b exp %b", c, obs_vld, exp_vld); end
            checks++; if (obs_stall !== exp_stall) begin errors++; $display("FAIL reset_stall_count c=%0d got %0d exp %0d", c, obs_stall, exp_stall); end
            if (c < 3) begin
                checks++; if (fd_in_ready !== 1'b0 || fd_out_valid !== 1'b0) begin
                    errors++; $display("FAIL reset_fd_handshake c=%0d got rdy=%b vld=%b exp 0 0", c, fd_in_ready, fd_out_valid);
                end
            end
        end
    endtask

    task automatic test_broadcast();
        md_en = '1; md_out_ready = '1;
        for (int c = 0; c < 35; c++) begin
            md_in_valid = (c < 32);
            md_in_data  = W'(c + 1);
            tick();
            checks++; if (obs_rdy !== exp_rdy || exp_rdy !== 1'b1) begin errors++; $display("FAIL bcast_in_tready c=%0d got %b exp 1", c, obs_rdy); end
            checks++; if (obs_vld !== exp_vld) begin errors++; $display("FAIL bcast_out_tvalid c=%0d got %b exp %b", c, obs_vld, exp_vld); end
            for (int n = 0; n < CH; n++) if (exp_vld[n]) begin
                checks++; if (obs_data[n] !== exp_data[n]) begin errors++; $display("FAIL bcast_tdata c=%0d ch%0d got %h exp %h", c, n, obs_data[n], exp_data[n]); end
            end
            checks++; if (obs_stall !== exp_stall) begin errors++; $display("FAIL bcast_stall_count c=%0d got %0d exp %0d", c, obs_stall, exp_stall); end
        end
    endtask

    task automatic test_fill_stall();
        int sent = 0, stalled = 0, c = 0;
        md_en = '1; md_out_ready = 4'b1011; md_in_valid = 1'b0; accepted = 1'b0;
        while ((sent < DEPTH + 4 || model_busy()) && c < 300) begin
            if (!md_in_valid || accepted) md_in_data = $urandom;
            md_in_valid = (sent < DEPTH + 4);
            tick();
            checks++; if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL fill_in_tready c=%0d got %b exp %b", c, obs_rdy, exp_rdy); end
            checks++; if (obs_vld !== exp_vld) begin errors++; $display("FAIL fill_out_tvalid c=%0d got %b exp %b", c, obs_vld, exp_vld); end
            for (int n = 0; n < CH; n++) if (exp_vld[n]) begin
                checks++; if (obs_data[n] !== exp_data[n]) begin errors++; $display("FAIL fill_tdata c=%0d ch%0d got %h exp %h", c, n, obs_data[n], exp_data[n]); end
            end
            checks++; if (obs_stall !== exp_stall) begin errors++; $display("FAIL fill_stall_count c=%0d got %0d exp %0d", c, obs_stall, exp_stall); end
            if (accepted) sent++;
            else if (md_in_valid) stalled++;
            if (stalled >= 5) md_out_ready = '1;
            c++;
        end
        md_in_valid = 1'b0;
        checks++; if (sent != DEPTH + 4 || stalled < 5) begin errors++; $display("FAIL fill_progress got sent=%0d stalled=%0d exp sent=%0d stalled>=5", sent, stalled, DEPTH + 4); end
    endtask

    task automatic test_enable_mask();
        logic [W-1:0]  t_data [5] = '{32'hA, 32'hB, 32'hC, 32'h0, 32'h0};
        logic [CH-1:0] t_en   [5] = '{4'b0101, 4'b0101, 4'b0000, 4'b0000, 4'b0000};
        logic          t_vld  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        md_out_ready = '1;
        for (int c = 0; c < 5; c++) begin
            md_in_data = t_data[c]; md_en = t_en[c]; md_in_valid = t_vld[c];
            tick();
            checks++; if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL mask_in_tready c=%0d got %b exp %b", c, obs_rdy, exp_rdy); end
            checks++; if (obs_vld !== exp_vld) begin errors++; $display("FAIL mask_out_tvalid c=%0d got %b exp %b", c, obs_vld, exp_vld); end
            for (int n = 0; n < CH; n++) if (exp_vld[n]) begin
                checks++; if (obs_data[n] !== exp_data[n]) begin errors++; $display("FAIL mask_tdata c=%0d ch%0d got %h exp %h", c, n, obs_data[n], exp_data[n]); end
            end
            checks++; if (obs_stall !== exp_stall) begin errors++; $display("FAIL mask_stall_count c=%0d got %0d exp %0d", c, obs_stall, exp_stall); end
        end
    endtask

    task automatic test_wrap_random();
        int sent = 0, c = 0;
        md_en = '1; md_in_valid = 1'b0; accepted = 1'b0;
        while ((sent < 50 || model_busy()) && c < 2000) begin
            if (!md_in_valid || accepted) begin
                md_in_data  = $urandom;
                md_in_valid = (sent < 50) && ($urandom_range(0, 3) != 0);
                md_en       = ($urandom_range(0, 3) == 0) ? CH'($urandom) : '1;
            end
            md_out_ready = (sent < 50) ? CH'($urandom) : '1;
            tick();
            checks++; if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL wrap_in_tready c=%0d got %b exp %b", c, obs_rdy, exp_rdy); end
            checks++; if (obs_vld !== exp_vld) begin errors++; $display("FAIL wrap_out_tvalid c=%0d got %b exp %b", c, obs_vld, exp_vld); end
            for (int n = 0; n < CH; n++) if (exp_vld[n]) begin
                checks++; if (obs_data[n] !== exp_data[n]) begin errors++; $display("FAIL wrap_tdata c=%0d ch%0d got %h exp %h", c, n, obs_data[n], exp_data[n]); end
            end
            checks++; if (obs_stall !== exp_stall) begin errors++; $display("FAIL wrap_stall_count c=%0d got %0d exp %0d", c, obs_stall, exp_stall); end
            if (accepted) sent++;
            c++;
        end
        md_in_valid = 1'b0;
        checks++; if (sent != 50) begin errors++; $display("FAIL wrap_progress got %0d exp 50", sent); end
    endtask

    task automatic test_reset_mid();
        md_en = '1; md_out_ready = '0;
        for (int c = 0; c < 8; c++) begin
            md_in_valid = (c < 5);
            md_in_data  = W'(32'h100 + c);
            if (c == 3) resetn = 1'b0;
            if (c == 5) begin resetn = 1'b1; md_out_ready = '1; end
            tick();
            checks++; if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL rstmid_in_tready c=%0d got %b exp %b", c, obs_rdy, exp_rdy); end
            checks++; if (obs_vld !== exp_vld) begin errors++; $display("FAIL rstmid_out_tvalid c=%0d got %b exp %b", c, obs_vld, exp_vld); end
            for (int n = 0; n < CH; n++) if (exp_vld[n]) begin
                checks++; if (obs_data[n] !== exp_data[n]) begin errors++; $display("FAIL rstmid_tdata c=%0d ch%0d got %h exp %h", c, n, obs_data[n], exp_data[n]); end
            end
            checks++; if (obs_stall !== exp_stall) begin errors++; $display("FAIL rstmid_stall_count c=%0d got %0d exp %0d", c, obs_stall, exp_stall); end
        end
    endtask

    task automatic test_frame_data();
`ifdef MINDY_FD_FIFO_EN
        logic [W-1:0] fq [$];
        int sent = 0, stalled = 0, c = 0;
        logic f_rdy, f_vld, f_acc = 1'b0;
        fd_out_ready = 1'b0; fd_in_valid = 1'b0;
        while ((sent < 20 || fq.size() != 0) && c < 500) begin
            if (!fd_in_valid || f_acc) fd_in_data = $urandom;
            fd_in_valid = (sent < 20);
            @(negedge clk);
            f_rdy = (fq.size() < FDD);
            f_vld = (fq.size() != 0);
            checks++; if (fd_in_ready !== f_rdy) begin errors++; $display("FAIL fd_in_tready c=%0d got %b exp %b", c, fd_in_ready, f_rdy); end
            checks++; if (fd_out_valid !== f_vld) begin errors++; $display("FAIL fd_out_tvalid c=%0d got %b exp %b", c, fd_out_valid, f_vld); end
            if (f_vld) begin
                checks++; if (fd_out_data !== fq[0]) begin errors++; $display("FAIL fd_out_tdata c=%0d got %h exp %h", c, fd_out_data, fq[0]); end
            end
            f_acc = fd_in_valid && f_rdy;
            if (f_vld && fd_out_ready) void'(fq.pop_front());
            if (f_acc) begin fq.push_back(fd_in_data); sent++; end
            else if (fd_in_valid) stalled++;
            @(posedge clk);
            #1;
            if (stalled >= 4) fd_out_ready = 1'b1;
            c++;
        end
        fd_in_valid = 1'b0;
        checks++; if (sent != 20) begin errors++; $display("FAIL fd_progress got %0d exp 20", sent); end
`else
        for (int c = 0; c < 16; c++) begin
            fd_in_data   = $urandom;
            fd_in_valid  = 1'($urandom);
            fd_out_ready = 1'($urandom);
            #1;
            checks++; if (fd_out_data !== fd_in_data) begin errors++; $display("FAIL fd_bypass_tdata c=%0d got %h exp %h", c, fd_out_data, fd_in_data); end
            checks++; if (fd_out_valid !== fd_in_valid) begin errors++; $display("FAIL fd_bypass_tvalid c=%0d got %b exp %b", c, fd_out_valid, fd_in_valid); end
            checks++; if (fd_in_ready !== fd_out_ready) begin errors++; $display("FAIL fd_bypass_tready c=%0d got %b exp %b", c, fd_in_ready, fd_out_ready); end
            @(posedge clk);
            #1;
        end
        fd_in_valid = 1'b0;
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout got no finish exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_stall = '0;
        test_reset();
        test_broadcast();
        test_fill_stall();
        test_enable_mask();
        test_wrap_random();
        test_reset_mid();
        test_frame_data();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mindy_md_fanout.md
# mindy_md_fanout

Parametrised meta-data/frame-data interface for the mindy core. It broadcasts every incoming meta-data beat to MD_CHANNELS independent output FIFOs, each with its own depth and its own back-pressure. A per-channel enable mask lets disabled consumers drop out without stalling the others. Frame data either passes straight through or is buffered in an optional FIFO. The block sits between the frame/meta-data producers and the downstream mindy consumers.

## Interface
- DATA_WBITS, 512, width of every TDATA bus
- MD_CHANNELS, 2, number of meta-data output channels, 1..8
- MD_DEPTH, 16, entries per meta-data FIFO, power of 2, >= 2
- FD_DEPTH, 16, entries in frame-data FIFO, power of 2, >= 2; used only with MINDY_FD_FIFO_EN
- clk  in  1  single clock for the whole block
- resetn  in  1  asynchronous, active-low reset
- AXIS_FD_IN_TDATA / _TVALID / _TREADY  in/in/out  DATA_WBITS/1/1  frame-data input stream
- AXIS_FD_OUT_TDATA / _TVALID / _TREADY  out/out/in  DATA_WBITS/1/1  frame-data output stream
- AXIS_MD_IN_TDATA / _TVALID / _TREADY  in/in/out  DATA_WBITS/1/1  meta-data input stream
- AXIS_MD_OUT_TDATA  out  MD_CHANNELS*DATA_WBITS  channel n occupies bits [n*DATA_WBITS +: DATA_WBITS]
- AXIS_MD_OUT_TVALID  out  MD_CHANNELS  per-channel valid
- AXIS_MD_OUT_TREADY  in  MD_CHANNELS  per-channel ready
- md_chan_en  in  MD_CHANNELS  1 = channel receives new meta-data
- md_stall_count  out  32  saturating count of cycles with MD_IN_TVALID=1 and MD_IN_TREADY=0

## Operation
- Each channel has a first-word-fall-through FIFO of MD_DEPTH entries. The FIFO uses read and write pointers of log2(MD_DEPTH)+1 bits.
  - Empty when the pointers are equal.
  - Full when the low bits are equal and the MSBs differ.
  - Pointers wrap naturally.
- AXIS_MD_IN_TREADY = resetn & AND over n of (!md_chan_en[n] | !full[n]).
- A meta-data handshake writes TDATA into every channel whose md_chan_en bit is 1 in that cycle. Disabled channels are not written.
- If md_chan_en is all zeros, TREADY=1 and each beat is accepted and discarded.
- Changing md_chan_en never removes entries already queued. A disabled channel still drains normally.
- For channel n:
  - AXIS_MD_OUT_TVALID[n] = !empty[n].
  - TDATA[n] is the head entry.
  - The read pointer advances on TVALID & TREADY.
- A write and a read on the same channel in the same cycle are both performed, and the occupancy is unchanged.
- md_stall_count increments on each stalled cycle and holds at 0xFFFFFFFF.
- While resetn=0:
  - All pointers and md_stall_count are cleared.
  - Every TVALID and TREADY output is 0.
  - FIFO contents are lost.
  - Reset may occur mid-transfer. Partial state is discarded, with no recovery.

## Timing
- Reset values:
  - all TVALID = 0 and all TREADY = 0;
  - md_stall_count = 0;
  - TDATA outputs are don't-care.
- Input TREADY depends only on registered full flags and md_chan_en. There is no combinational path from any output TREADY to any input TREADY.
- A full FIFO whose head is read in the same cycle still deasserts input TREADY for that cycle.
- Meta-data latency: a handshake at cycle t gives TVALID=1 on enabled channels at cycle t+1.
- Sustained throughput is 1 beat/cycle when all enabled consumers hold TREADY=1.
- A channel holding TREADY=0 fills after MD_DEPTH beats and then stalls the input. Other channels keep draining their queued entries.

## Configuration
- Macro: MINDY_FD_FIFO_EN.
- Defined: frame data passes through an FD_DEPTH first-word-fall-through FIFO with the same pointer scheme.
  - AXIS_FD_IN_TREADY = resetn & !fd_full.
  - Latency is 1 cycle.
  - Throughput is 1 beat/cycle.
- Undefined: frame data is combinational.
  - AXIS_FD_OUT_TDATA = AXIS_FD_IN_TDATA.
  - AXIS_FD_OUT_TVALID = AXIS_FD_IN_TVALID & resetn.
  - AXIS_FD_IN_TREADY = AXIS_FD_OUT_TREADY & resetn.
  - FD_DEPTH is ignored.

## Test plan
- Broadcast: MD_CHANNELS=4, all enabled, all TREADY=1. Send 0x01..0x20 back-to-back -> each channel emits 0x01..0x20 in order, one cycle after each input beat, with no input stall.
- Fill/stall: MD_DEPTH=16, channel 2 TREADY=0, others TREADY=1. Send 20 beats -> input TREADY drops after beat 16 and md_stall_count counts the stalled cycles. Raising channel 2 TREADY releases all 20 beats in order on every channel.
- Enable mask: md_chan_en=0b0101, send 0xA, 0xB -> only channels 0 and 2 emit them. With md_chan_en=0, send 0xC -> accepted in 1 cycle and emitted nowhere.
- Wrap/simultaneous: MD_DEPTH=4, run 50 beats with random TREADY -> no loss, no duplication, order preserved through several pointer wraps.
- Reset mid-operation: 3 entries queued, assert resetn=0 for 2 cycles -> all TVALID/TREADY are 0 during reset. After release the FIFOs are empty and md_stall_count=0.
- Frame data: with MINDY_FD_FIFO_EN, send 20 beats with output TREADY=0 -> input TREADY drops after FD_DEPTH beats, then data drains in order. Without the macro, output mirrors input in the same cycle.
